// File: rtl/matmul_sequencer_if.sv
// matmul_sequencer_if: address/accumulator control bus between the matmul sequencer and its datapath.
interface matmul_sequencer_if #(parameter int DIM = 3);
    localparam int AW = $clog2(DIM*DIM);
    logic start;
    logic abort;
    logic [AW-1:0] read_addr_M1;
    logic [AW-1:0] read_addr_M2;
    logic addr_valid;
    logic acc_en;
    logic acc_load;
    logic res_valid;
    logic [AW-1:0] res_addr;
    logic busy;
    logic done;
    modport master (
        input  start, abort,
        output read_addr_M1, read_addr_M2, addr_valid, acc_en, acc_load,
               res_valid, res_addr, busy, done
    );
    modport slave (
        output start, abort,
        input  read_addr_M1, read_addr_M2, addr_valid, acc_en, acc_load,
               res_valid, res_addr, busy, done
    );
endinterface

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: issues i/j/k read addresses for C = M1 x M2 and times the accumulator controls.
module matmul_sequencer #(
    parameter int DIM = 3,
    parameter int LAT = 2
) (
    input logic clk_fast,
    input logic rst,
    matmul_sequencer_if.master bus
);
    localparam int AW = $clog2(DIM*DIM);
    localparam int CW = $clog2(DIM);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
    localparam logic [CW-1:0] LAST = CW'(DIM-1);
    localparam logic [AW-1:0] DIM_A = AW'(DIM);

    logic [1:0] state, state_n;
    logic [CW-1:0] i, j, k, i_n, j_n, k_n;
    logic [2:0] cnt;
    logic [AW-1:0] addr_m1, addr_m2, res_addr;
    logic addr_valid, res_valid, busy, done;
    logic clear, last_issue;
    logic [LAT-1:0] av_sr, ld_sr, last_sr;
    logic [AW-1:0] ij_sr [LAT];

    always_comb begin
        clear = rst || (bus.abort && state != IDLE);
        last_issue = i == LAST && j == LAST && k == LAST;
        k_n = k == LAST ? '0 : k + 1'b1;
        j_n = k != LAST ? j : (j == LAST ? '0 : j + 1'b1);
        i_n = (k != LAST || j != LAST) ? i : (i == LAST ? '0 : i + 1'b1);
        state_n = state == IDLE  ? (bus.start ? RUN : IDLE) :
                  state == RUN   ? (last_issue ? DRAIN : RUN) :
                  state == DRAIN ? (cnt == 3'(LAT) ? DONE : DRAIN) : IDLE;
    end

    // Counters always hold the pair currently on the address outputs, so the
    // k==0 / k==DIM-1 tags enter the delay lines aligned with addr_valid.
    always_ff @(posedge clk_fast) begin
        if (clear) begin
            state <= IDLE;
            i <= '0;
            j <= '0;
            k <= '0;
            cnt <= '0;
            addr_m1 <= '0;
            addr_m2 <= '0;
            res_addr <= '0;
            addr_valid <= 1'b0;
            res_valid <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            av_sr <= '0;
            ld_sr <= '0;
            last_sr <= '0;
            for (int n = 0; n < LAT; n++) ij_sr[n] <= '0;
        end else begin
            state <= state_n;
            busy <= state_n != IDLE;
            done <= state_n == DONE;
            addr_valid <= state_n == RUN;
            cnt <= state == DRAIN ? cnt + 3'd1 : 3'd0;
            if (state == RUN) begin
                i <= i_n;
                j <= j_n;
                k <= k_n;
            end
            if (state_n == RUN) begin
                addr_m1 <= state == RUN ? AW'(i_n) * DIM_A + AW'(k_n) : '0;
                addr_m2 <= state == RUN ? AW'(k_n) * DIM_A + AW'(j_n) : '0;
            end
            av_sr[0] <= addr_valid;
            ld_sr[0] <= addr_valid && k == '0;
            last_sr[0] <= addr_valid && k == LAST;
            ij_sr[0] <= AW'(i) * DIM_A + AW'(j);
            for (int n = 1; n < LAT; n++) begin
                av_sr[n] <= av_sr[n-1];
                ld_sr[n] <= ld_sr[n-1];
                last_sr[n] <= last_sr[n-1];
                ij_sr[n] <= ij_sr[n-1];
            end
            res_valid <= last_sr[LAT-1];
            if (last_sr[LAT-1]) res_addr <= ij_sr[LAT-1];
        end
    end

    assign bus.read_addr_M1 = addr_m1;
    assign bus.read_addr_M2 = addr_m2;
    assign bus.addr_valid = addr_valid;
    assign bus.acc_en = av_sr[LAT-1];
    assign bus.acc_load = ld_sr[LAT-1];
    assign bus.res_valid = res_valid;
    assign bus.res_addr = res_addr;
    assign bus.busy = busy;
    assign bus.done = done;
endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: directed timing checks on a DIM=3/LAT=2 sequencer and a
// complex-product scoreboard on a DIM=2/LAT=1 sequencer.
module tb_matmul_sequencer;
    logic clk_slow_tb = 1'b0;
    logic rst;
    always #5 clk_slow_tb = ~clk_slow_tb;

    matmul_sequencer_if #(.DIM(3)) bus1();
    matmul_sequencer_if #(.DIM(2)) bus2();
    matmul_sequencer #(.DIM(3), .LAT(2)) dut1 (.clk_fast(clk_slow_tb), .rst(rst), .bus(bus1));
    matmul_sequencer #(.DIM(2), .LAT(1)) dut2 (.clk_fast(clk_slow_tb), .rst(rst), .bus(bus2));

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int cyc;
        int av, m1, m2, ae, al, rv, ra, busy, done;
    } vec_t;
    vec_t tbl[$];

    int m1r[4], m1i[4], m2r[4], m2i[4], cr[4], ci[4];
    int pr, pi, ar, ai;

    // One-register product stage plus accumulator, as the LAT=1 datapath would have.
    always @(posedge clk_slow_tb) begin
        pr <= m1r[bus2.read_addr_M1] * m2r[bus2.read_addr_M2] - m1i[bus2.read_addr_M1] * m2i[bus2.read_addr_M2];
        pi <= m1r[bus2.read_addr_M1] * m2i[bus2.read_addr_M2] + m1i[bus2.read_addr_M1] * m2r[bus2.read_addr_M2];
        if (bus2.acc_en) begin
            ar <= bus2.acc_load ? pr : ar + pr;
            ai <= bus2.acc_load ? pi : ai + pi;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_slow_tb);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " m1"}, bus1.read_addr_M1, 0);
        chk({tag, " m2"}, bus1.read_addr_M2, 0);
        chk({tag, " res_addr"}, bus1.res_addr, 0);
        chk({tag, " addr_valid"}, bus1.addr_valid, 0);
        chk({tag, " acc_en"}, bus1.acc_en, 0);
        chk({tag, " acc_load"}, bus1.acc_load, 0);
        chk({tag, " res_valid"}, bus1.res_valid, 0);
        chk({tag, " busy"}, bus1.busy, 0);
        chk({tag, " done"}, bus1.done, 0);
    endtask

    task automatic check_cycle(input string tag, input int c);
        string p;
        int erv;
        p = $sformatf("%s c%0d", tag, c);
        erv = (c >= 6 && c <= 30 && c % 3 == 0) ? 1 : 0;
        chk({p, " addr_valid"}, bus1.addr_valid, (c >= 1 && c <= 27) ? 1 : 0);
        chk({p, " acc_en"}, bus1.acc_en, (c >= 3 && c <= 29) ? 1 : 0);
        chk({p, " acc_load"}, bus1.acc_load, (c >= 3 && c <= 27 && c % 3 == 0) ? 1 : 0);
        chk({p, " res_valid"}, bus1.res_valid, erv);
        if (erv == 1) chk({p, " res_addr"}, bus1.res_addr, c / 3 - 2);
        chk({p, " busy"}, bus1.busy, (c >= 1 && c <= 31) ? 1 : 0);
        chk({p, " done"}, bus1.done, c == 31 ? 1 : 0);
        foreach (tbl[n]) if (tbl[n].cyc == c) begin
            chk({p, " tbl av"}, bus1.addr_valid, tbl[n].av);
            chk({p, " tbl m1"}, bus1.read_addr_M1, tbl[n].m1);
            chk({p, " tbl m2"}, bus1.read_addr_M2, tbl[n].m2);
            chk({p, " tbl acc_en"}, bus1.acc_en, tbl[n].ae);
            chk({p, " tbl acc_load"}, bus1.acc_load, tbl[n].al);
            chk({p, " tbl res_valid"}, bus1.res_valid, tbl[n].rv);
            if (tbl[n].ra >= 0) chk({p, " tbl res_addr"}, bus1.res_addr, tbl[n].ra);
            chk({p, " tbl busy"}, bus1.busy, tbl[n].busy);
            chk({p, " tbl done"}, bus1.done, tbl[n].done);
        end
    endtask

    task automatic run_product(input string tag, input bit poke_start);
        int rv_cnt, done_cnt;
        rv_cnt = 0;
        done_cnt = 0;
        bus1.start = 1'b1;
        step();
        bus1.start = 1'b0;
        for (int c = 1; c <= 33; c++) begin
            if (c > 1) step();
            bus1.start = (poke_start && c == 12) ? 1'b1 : 1'b0;
            check_cycle(tag, c);
            rv_cnt += int'(bus1.res_valid);
            done_cnt += int'(bus1.done);
        end
        bus1.start = 1'b0;
        chk({tag, " res_valid count"}, rv_cnt, 9);
        chk({tag, " done count"}, done_cnt, 1);
    endtask

    initial begin
        int bad, seen, idx;
        tbl.push_back('{1, 1, 0, 0, 0, 0, 0, -1, 1, 0});
        tbl.push_back('{2, 1, 1, 3, 0, 0, 0, -1, 1, 0});
        tbl.push_back('{3, 1, 2, 6, 1, 1, 0, -1, 1, 0});
        tbl.push_back('{4, 1, 0, 1, 1, 0, 0, -1, 1, 0});
        tbl.push_back('{5, 1, 1, 4, 1, 0, 0, -1, 1, 0});
        tbl.push_back('{6, 1, 2, 7, 1, 1, 1, 0, 1, 0});
        tbl.push_back('{9, 1, 2, 8, 1, 1, 1, 1, 1, 0});
        tbl.push_back('{10, 1, 3, 0, 1, 0, 0, -1, 1, 0});
        tbl.push_back('{27, 1, 8, 8, 1, 1, 1, 7, 1, 0});
        tbl.push_back('{28, 0, 8, 8, 1, 0, 0, -1, 1, 0});
        tbl.push_back('{29, 0, 8, 8, 1, 0, 0, -1, 1, 0});
        tbl.push_back('{30, 0, 8, 8, 0, 0, 1, 8, 1, 0});
        tbl.push_back('{31, 0, 8, 8, 0, 0, 0, -1, 1, 1});
        tbl.push_back('{32, 0, 8, 8, 0, 0, 0, -1, 0, 0});

        rst = 1'b1;
        bus1.start = 1'b1;
        bus1.abort = 1'b1;
        bus2.start = 1'b0;
        bus2.abort = 1'b0;
        step();
        step();
        check_reset("reset prio");
        rst = 1'b0;
        bus1.start = 1'b0;
        bus1.abort = 1'b0;
        step();

        run_product("nominal", 1'b0);

        bus1.start = 1'b1;
        step();
        bus1.start = 1'b0;
        for (int c = 2; c <= 10; c++) step();
        bus1.abort = 1'b1;
        step();
        bus1.abort = 1'b0;
        chk("abort c11 busy", bus1.busy, 0);
        chk("abort c11 addr_valid", bus1.addr_valid, 0);
        chk("abort c11 acc_en", bus1.acc_en, 0);
        chk("abort c11 res_valid", bus1.res_valid, 0);
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            bad += int'(bus1.acc_en) + int'(bus1.res_valid) + int'(bus1.done) + int'(bus1.busy);
            step();
        end
        chk("abort quiet", bad, 0);
        run_product("after abort", 1'b1);

        bus1.start = 1'b1;
        step();
        bus1.start = 1'b0;
        for (int c = 2; c <= 15; c++) step();
        rst = 1'b1;
        bus1.start = 1'b1;
        step();
        check_reset("rst c16");
        step();
        check_reset("rst c17");
        rst = 1'b0;
        bus1.start = 1'b0;
        step();

        bus1.start = 1'b1;
        step();
        for (int c = 2; c <= 31; c++) step();
        chk("b2b c31 done", bus1.done, 1);
        step();
        chk("b2b c32 busy", bus1.busy, 0);
        chk("b2b c32 addr_valid", bus1.addr_valid, 0);
        step();
        chk("b2b c33 addr_valid", bus1.addr_valid, 1);
        chk("b2b c33 m1", bus1.read_addr_M1, 0);
        chk("b2b c33 m2", bus1.read_addr_M2, 0);
        bus1.start = 1'b0;
        step();
        chk("b2b c34 m1", bus1.read_addr_M1, 1);
        chk("b2b c34 m2", bus1.read_addr_M2, 3);
        seen = 0;
        for (int c = 0; c < 40 && seen == 0; c++) begin
            step();
            seen = int'(bus1.done);
        end
        chk("b2b second done", seen, 1);
        step();

        bus1.start = 1'b1;
        bus1.abort = 1'b1;
        step();
        bus1.start = 1'b0;
        bus1.abort = 1'b0;
        chk("start+abort idle busy", bus1.busy, 1);
        chk("start+abort idle addr_valid", bus1.addr_valid, 1);
        bus1.abort = 1'b1;
        step();
        bus1.abort = 1'b0;
        chk("abort run busy", bus1.busy, 0);

        for (int n = 0; n < 4; n++) begin
            m1r[n] = int'($urandom_range(0, 20)) - 10;
            m1i[n] = int'($urandom_range(0, 20)) - 10;
            m2r[n] = int'($urandom_range(0, 20)) - 10;
            m2i[n] = int'($urandom_range(0, 20)) - 10;
        end
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                cr[r*2+c] = 0;
                ci[r*2+c] = 0;
                for (int q = 0; q < 2; q++) begin
                    cr[r*2+c] += m1r[r*2+q] * m2r[q*2+c] - m1i[r*2+q] * m2i[q*2+c];
                    ci[r*2+c] += m1r[r*2+q] * m2i[q*2+c] + m1i[r*2+q] * m2r[q*2+c];
                end
            end
        bus2.start = 1'b1;
        step();
        bus2.start = 1'b0;
        idx = 0;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            if (bus2.res_valid) begin
                chk($sformatf("sb res_addr #%0d", idx), bus2.res_addr, idx);
                chk($sformatf("sb re C[%0d]", idx), ar, cr[idx & 3]);
                chk($sformatf("sb im C[%0d]", idx), ai, ci[idx & 3]);
                idx++;
            end
            seen += int'(bus2.done);
            step();
        end
        chk("sb res_valid count", idx, 4);
        chk("sb done count", seen, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/matmul_sequencer.md
MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 SHALL have parameter DIM, default 3: square matrix dimension; legal range 2..16.
REQ-002 SHALL have parameter LAT, default 2: cycles from read-address issue to accumulator input valid (RAM read plus multiplier register); legal range 1..4.
REQ-003 SHALL define localparam AW = $clog2(DIM*DIM) as the address width.
REQ-004 clk_fast  in  1  sole clock; all logic updates on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  level; sampled high in IDLE, it begins one full C = M1 x M2 product.
REQ-007 abort  in  1  sampled high in any non-IDLE state, it returns the block to IDLE.
REQ-008 read_addr_M1  out  AW  row-major element address into M1 (real and imag RAMs).
REQ-009 read_addr_M2  out  AW  row-major element address into M2 (real and imag RAMs).
REQ-010 addr_valid  out  1  read addresses valid this cycle.
REQ-011 acc_en  out  1  accumulators (real and imag) take the current product this cycle.
REQ-012 acc_load  out  1  with acc_en, the accumulator loads the product instead of adding it (first term).
REQ-013 res_valid  out  1  one-cycle pulse: accumulators hold a finished C element.
REQ-014 res_addr  out  AW  row-major index of the C element flagged by res_valid.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse at the end of a product.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN and DONE.
REQ-018 Transitions:
- IDLE->RUN on start.
- RUN->DRAIN after the issue with i=j=k=DIM-1.
- DRAIN->DONE after LAT+1 cycles.
- DONE->IDLE unconditionally.
REQ-019 In RUN, exactly one address pair SHALL be issued per cycle, with addr_valid=1, read_addr_M1=i*DIM+k and read_addr_M2=k*DIM+j.
REQ-020 Counter k SHALL be innermost, then j, then i; each counter wraps DIM-1->0 and carries into the next outer counter.
REQ-021 RUN SHALL last exactly DIM^3 cycles.
REQ-022 acc_en SHALL equal addr_valid delayed by exactly LAT cycles (shift register).
REQ-023 acc_load SHALL equal (addr_valid and k==0) delayed by LAT cycles.
REQ-024 res_valid SHALL equal (addr_valid and k==DIM-1) delayed by LAT+1 cycles.
REQ-025 res_addr SHALL equal i*DIM+j of that issue, delayed by LAT+1 cycles; it is held between pulses.
REQ-026 Output ordering:
- res_valid SHALL pulse DIM^2 times per product, with res_addr values 0..DIM^2-1 in ascending order.
- No two res_valid pulses SHALL occur in consecutive cycles when DIM>=2.
REQ-027 When addr_valid=0, read addresses SHALL hold their last value.
REQ-028 done SHALL be high for exactly the single DONE cycle; busy SHALL be low in that cycle's successor.
REQ-029 start while busy SHALL be ignored. start held high through DONE SHALL begin a new product in the cycle after DONE, with no lost cycles beyond the one IDLE cycle.
REQ-030 On abort:
- Next cycle: IDLE, counters=0, all delay-line stages cleared.
- acc_en, acc_load and res_valid SHALL be 0 from that cycle on, and no done pulse SHALL occur.
REQ-031 When start and abort are both high in IDLE, start SHALL win; abort has effect only in non-IDLE states.
REQ-032 All outputs SHALL be registered; no combinational path from start or abort to any output.

Reset
REQ-033 rst=1 at a clock edge SHALL force IDLE, i=j=k=0 and clear all delay-line stages, from any state including mid-RUN.
REQ-034 After reset, outputs SHALL be: read_addr_M1=0, read_addr_M2=0, res_addr=0, and addr_valid=acc_en=acc_load=res_valid=busy=done=0.
REQ-035 rst SHALL take priority over start and abort.

Verification
REQ-036 Nominal: DIM=3, LAT=2, start pulsed at edge 0 -> checks:
- addr_valid high for cycles 1..27.
- Cycle 1: M1=0, M2=0; cycle 2: M1=1, M2=3; cycle 3: M1=2, M2=6; cycle 4: M1=0, M2=1.
- acc_en high for cycles 3..29; acc_load high at cycles 3, 6, ..., 27.
- res_valid at cycles 6, 9, ..., 30 with res_addr 0..8.
- done at cycle 31; busy low from cycle 32.
REQ-037 Last issue: cycle 27 -> M1=8, M2=8; the following cycle addr_valid=0 and state is DRAIN.
REQ-038 Abort at cycle 10 -> from cycle 11: busy=0, acc_en=0, res_valid=0, no done pulse. A new start then reproduces the REQ-036 timing.
REQ-039 rst asserted at cycle 15 -> all outputs at reset values from cycle 16, regardless of start.
REQ-040 start held high continuously -> back-to-back products:
- done at cycle 31, IDLE at cycle 32, addr_valid again at cycle 33.
- start pulses during RUN have no effect.
REQ-041 Scoreboard with DIM=2, LAT=1 and a LAT=1 datapath model, random complex M1/M2 -> each res_valid value equals the reference C[res_addr]; exactly 4 res_valid pulses and 1 done pulse.
